// File: rtl/sync_in_pkg.sv
// Shared types and default constants for the sync-input conditioning path.
// The state encoding is fixed so it can be read directly from the debug port.
package sync_in_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } sync_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_LEN     = 4;
    localparam int DEF_STRETCH_LEN    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_INT_PERIOD     = 500000;
    localparam int DEF_PERIOD_W       = 32;

endpackage

// File: rtl/sync_deglitch.sv
// Resynchronises the raw sync line and filters it: the level only changes after
// FILTER_LEN consecutive samples disagree with it. 'rise' strobes on a 0->1 flip.
module sync_deglitch
    import sync_in_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   w_sample;
    logic                   w_differs;
    logic                   w_flip;

    assign w_sample  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sample != r_level);
    assign w_flip    = w_differs && (r_cnt == FILT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Counter tracks the current run of disagreeing samples; any agreeing sample restarts it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= w_flip & w_sample;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= w_sample;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/sync_in_conditioner.sv
// Conditions the external sync line for the sync-input PIO: deglitch, lock and
// period measurement, internal fallback while the source is lost, and a stretched output level.
module sync_in_conditioner
    import sync_in_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int STRETCH_LEN    = DEF_STRETCH_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int INT_PERIOD     = DEF_INT_PERIOD,
    parameter int PERIOD_W       = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                sync_raw,
    output logic                sync_out,
    output logic                sync_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                sync_lost,
    output logic                using_internal,
    output sync_state_t         dbg_state
);

    localparam int ST_W = $clog2(STRETCH_LEN + 1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = PERIOD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] INT_LAST     = PERIOD_W'(INT_PERIOD - 1);
    localparam logic [ST_W-1:0]     STRETCH_LOAD = ST_W'(STRETCH_LEN);

    sync_state_t         r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_int_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_period_valid;
    logic                r_sync_pulse;
    logic                r_sync_lost;
    logic                r_using_int;
    logic [ST_W-1:0]     r_st_cnt;
    logic                r_sync_out;

    logic                w_level;
    logic                w_rise;
    logic                w_edge;
    logic                w_tick;
    logic                w_pulse;
    sync_state_t         w_state_nxt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic [PERIOD_W-1:0] w_int_cnt_nxt;
    logic [PERIOD_W-1:0] w_period_nxt;
    logic                w_period_valid_nxt;
    logic                w_sync_lost_nxt;
    logic                w_using_int_nxt;

    sync_deglitch #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_deglitch (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync_raw),
        .level   (w_level),
        .rise    (w_rise)
    );

    // The rise strobe coincides with the level going high; gating on it keeps the edge definition explicit.
    assign w_edge = w_rise & w_level;
    assign w_tick = (r_int_cnt == INT_LAST);

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_int_cnt_nxt      = r_int_cnt;
        w_period_nxt       = r_period;
        w_period_valid_nxt = r_period_valid;
        w_sync_lost_nxt    = r_sync_lost;
        w_using_int_nxt    = r_using_int;
        w_pulse            = 1'b0;

        if (!enable) begin
            w_state_nxt        = ST_IDLE;
            w_cnt_nxt          = '0;
            w_int_cnt_nxt      = '0;
            w_period_valid_nxt = 1'b0;
            w_sync_lost_nxt    = 1'b0;
            w_using_int_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_edge) begin
                        w_pulse     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_edge) begin
                        w_pulse            = 1'b1;
                        w_period_nxt       = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                        w_period_valid_nxt = 1'b1;
                        w_cnt_nxt          = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        // Loss is declared with an immediate internal sync so the CPU sees no gap.
                        w_state_nxt        = ST_LOST;
                        w_pulse            = 1'b1;
                        w_sync_lost_nxt    = 1'b1;
                        w_using_int_nxt    = 1'b1;
                        w_period_valid_nxt = 1'b0;
                        w_int_cnt_nxt      = '0;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_LOST: begin
                    if (w_edge) begin
                        w_pulse         = 1'b1;
                        w_state_nxt     = ST_LOCKED;
                        w_sync_lost_nxt = 1'b0;
                        w_using_int_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                    end else if (w_tick) begin
                        w_pulse       = 1'b1;
                        w_int_cnt_nxt = '0;
                    end else begin
                        w_int_cnt_nxt = r_int_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_int_cnt      <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_sync_pulse   <= 1'b0;
            r_sync_lost    <= 1'b0;
            r_using_int    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_int_cnt      <= w_int_cnt_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_sync_pulse   <= w_pulse;
            r_sync_lost    <= w_sync_lost_nxt;
            r_using_int    <= w_using_int_nxt;
        end
    end

    // A pulse during an active stretch reloads it, so the PIO sees one continuous high level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_st_cnt   <= '0;
            r_sync_out <= 1'b0;
        end else if (!enable) begin
            r_st_cnt   <= '0;
            r_sync_out <= 1'b0;
        end else if (w_pulse) begin
            r_st_cnt   <= STRETCH_LOAD;
            r_sync_out <= 1'b1;
        end else if (r_st_cnt != '0) begin
            r_st_cnt   <= r_st_cnt - 1'b1;
            r_sync_out <= (r_st_cnt != ST_W'(1));
        end
    end

    assign sync_out       = r_sync_out;
    assign sync_pulse     = r_sync_pulse;
    assign period         = r_period;
    assign period_valid   = r_period_valid;
    assign sync_lost      = r_sync_lost;
    assign using_internal = r_using_int;
    assign dbg_state      = r_state;

endmodule
